// File: rtl/row_span_sequencer_if.sv
// Instruction-in / span-out handshake bundle for row_span_sequencer.
// The slave modport is the sequencer's view; master is the buffer/core side.
interface row_span_sequencer_if #(
   parameter int INSTRUCTION_WIDTH = 52,
   parameter int COORD_WIDTH       = 12
);
   logic                         instr_valid;
   logic                         instr_ready;
   logic                         instr_last;
   logic [INSTRUCTION_WIDTH-1:0] instr_data;
   logic                         span_valid;
   logic                         span_ready;
   logic [COORD_WIDTH-1:0]       span_row;
   logic [COORD_WIDTH-1:0]       span_x_lo;
   logic [COORD_WIDTH-1:0]       span_x_hi;
   logic [1:0]                   span_op;
   logic                         span_last;
   logic                         all_done;

   modport slave (
      input  instr_valid, instr_last, instr_data, span_ready,
      output instr_ready, span_valid, span_row, span_x_lo, span_x_hi,
             span_op, span_last, all_done
   );

   modport master (
      output instr_valid, instr_last, instr_data, span_ready,
      input  instr_ready, span_valid, span_row, span_x_lo, span_x_hi,
             span_op, span_last, all_done
   );
endinterface

// File: rtl/row_span_sequencer.sv
// Expands rectangle instructions into one single-row span per grid row, y_lo..y_hi.
// Optional statistics counters are built when SPAN_STATS_EN is defined.
module row_span_sequencer #(
   parameter int INSTRUCTION_WIDTH = 52,
   parameter int COORD_WIDTH       = 12,
   parameter int STATS_WIDTH       = 24
) (
   input  logic                   clk,
   input  logic                   reset_n,
   row_span_sequencer_if.slave    bus
`ifdef SPAN_STATS_EN
   ,
   output logic [STATS_WIDTH-1:0] stat_instr_count,
   output logic [STATS_WIDTH-1:0] stat_span_count,
   output logic [STATS_WIDTH-1:0] stat_drop_count
`endif
);
   localparam int CW = COORD_WIDTH;
   localparam int IW = INSTRUCTION_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_r, state_s;
   logic [CW-1:0]   row_r, row_s;
   logic [CW-1:0]   x_lo_r, x_lo_s;
   logic [CW-1:0]   x_hi_r, x_hi_s;
   logic [CW-1:0]   y_hi_r, y_hi_s;
   logic [1:0]      op_r, op_s;
   logic            last_r, last_s;
   logic            instr_ready_r, span_valid_r, span_last_r, all_done_r;
   logic            accept_s, span_hs_s, drop_s;
   logic [1:0]      in_op_s;
   logic [CW-1:0]   x0_s, y0_s, x1_s, y1_s;

   assign in_op_s   = bus.instr_data[IW-1 -: 2];
   assign x0_s      = bus.instr_data[IW-3 -: CW];
   assign y0_s      = bus.instr_data[IW-3-CW -: CW];
   assign x1_s      = bus.instr_data[IW-3-2*CW -: CW];
   assign y1_s      = bus.instr_data[IW-3-3*CW -: CW];
   assign accept_s  = instr_ready_r && bus.instr_valid;
   assign span_hs_s = span_valid_r && bus.span_ready;

   // Next-state and next-value logic for the sequencer.
   always_comb begin
      state_s = state_r;
      row_s   = row_r;
      x_lo_s  = x_lo_r;
      x_hi_s  = x_hi_r;
      y_hi_s  = y_hi_r;
      op_s    = op_r;
      last_s  = last_r;
      drop_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               op_s   = in_op_s;
               x_lo_s = (x0_s < x1_s) ? x0_s : x1_s;
               x_hi_s = (x0_s < x1_s) ? x1_s : x0_s;
               y_hi_s = (y0_s < y1_s) ? y1_s : y0_s;
               row_s  = (y0_s < y1_s) ? y0_s : y1_s;
               last_s = bus.instr_last;
               if (in_op_s == 2'b00) begin
                  drop_s  = !bus.instr_last;
                  state_s = bus.instr_last ? ST_DONE : ST_IDLE;
               end else begin
                  state_s = ST_EMIT;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_EMIT: begin
            if (span_hs_s) begin
               if (row_r == y_hi_r) begin
                  state_s = last_r ? ST_DONE : ST_IDLE;
               end else begin
                  row_s = row_r + CW'(1);
               end
            end else begin
               state_s = ST_EMIT;
            end
         end
         ST_DONE: state_s = ST_DONE;
         default: state_s = ST_IDLE;
      endcase
   end

   // State, latched coordinates and registered handshake outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= ST_IDLE;
         row_r         <= {CW{1'b0}};
         x_lo_r        <= {CW{1'b0}};
         x_hi_r        <= {CW{1'b0}};
         y_hi_r        <= {CW{1'b0}};
         op_r          <= 2'b00;
         last_r        <= 1'b0;
         instr_ready_r <= 1'b0;
         span_valid_r  <= 1'b0;
         span_last_r   <= 1'b0;
         all_done_r    <= 1'b0;
      end else begin
         state_r       <= state_s;
         row_r         <= row_s;
         x_lo_r        <= x_lo_s;
         x_hi_r        <= x_hi_s;
         y_hi_r        <= y_hi_s;
         op_r          <= op_s;
         last_r        <= last_s;
         instr_ready_r <= (state_s == ST_IDLE);
         span_valid_r  <= (state_s == ST_EMIT);
         span_last_r   <= (state_s == ST_EMIT) && last_s && (row_s == y_hi_s);
         all_done_r    <= (state_s == ST_DONE);
      end
   end

   assign bus.instr_ready = instr_ready_r;
   assign bus.span_valid  = span_valid_r;
   assign bus.span_row    = row_r;
   assign bus.span_x_lo   = x_lo_r;
   assign bus.span_x_hi   = x_hi_r;
   assign bus.span_op     = op_r;
   assign bus.span_last   = span_last_r;
   assign bus.all_done    = all_done_r;

`ifdef SPAN_STATS_EN
   function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] v);
      return (&v) ? v : v + STATS_WIDTH'(1);
   endfunction

   logic [STATS_WIDTH-1:0] stat_instr_r, stat_span_r, stat_drop_r;

   // Saturating event counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_instr_r <= {STATS_WIDTH{1'b0}};
         stat_span_r  <= {STATS_WIDTH{1'b0}};
         stat_drop_r  <= {STATS_WIDTH{1'b0}};
      end else begin
         stat_instr_r <= accept_s  ? sat_inc(stat_instr_r) : stat_instr_r;
         stat_span_r  <= span_hs_s ? sat_inc(stat_span_r)  : stat_span_r;
         stat_drop_r  <= drop_s    ? sat_inc(stat_drop_r)  : stat_drop_r;
      end
   end

   assign stat_instr_count = stat_instr_r;
   assign stat_span_count  = stat_span_r;
   assign stat_drop_count  = stat_drop_r;
`endif
endmodule
